cic_agc: RTL
============

# cic_agc

Automatic gain controller for the CIC decimator's `gain` input. It watches the decimated output samples, tracks the peak magnitude over a fixed window, and steps the CIC output shift up or down by one bit. After each change it waits for the comb pipeline to settle before it measures again. It sits beside the CIC, drives its `gain` port directly, and falls back to a software-supplied manual gain when AGC is disabled.

## Interface
- `DATA_WIDTH`, 12: width of the CIC output sample.
- `GAIN_WIDTH`, 8: width of the gain word driven to the CIC.
- `WINDOW`, 256: valid samples per peak-measurement window, ≥2.
- `SETTLE`, 8: valid samples discarded after a gain change, ≥1. It must be ≥ CIC stage count.
- `HIGH_THRESH`, 1536: peak above this value decrements gain.
- `LOW_THRESH`, 640: peak below this value increments gain. Requires LOW_THRESH < HIGH_THRESH/2 (hysteresis).
- `GAIN_MIN`, 0: lower gain bound.
- `GAIN_MAX`, 52: upper gain bound. Equals CIC register width − DATA_WIDTH, so the CIC shift is never negative.
- `GAIN_INIT`, 0: gain value at reset.

Ports:
- `clk` in 1: system clock. Only clock.
- `rst` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: one-cycle strobe per decimated CIC sample.
- `sample` in DATA_WIDTH, signed: CIC output, qualified by `sample_valid`.
- `agc_enable` in 1: 1 = automatic, 0 = manual.
- `manual_gain` in GAIN_WIDTH: gain used in manual mode.
- `gain` out GAIN_WIDTH: gain to the CIC.
- `gain_changed` out 1: one-cycle pulse on the cycle `gain` takes a new value.
- `peak_level` out DATA_WIDTH−1: peak magnitude of the last completed window.
- `locked` out 1: the last window needed no change.

## Operation
- **Magnitude:** |sample|. The most-negative input saturates to 2^(DATA_WIDTH−1)−1. Result is unsigned, DATA_WIDTH−1 bits.
- **FSM states:** MANUAL, MEASURE, DECIDE, SETTLE. The reset state is MANUAL.
- **MANUAL:**
  - Each cycle, `gain` ← min(`manual_gain`, GAIN_MAX).
  - The window counter and peak are held at 0, and `locked` = 0.
  - When `agc_enable` = 1, the FSM goes to MEASURE and `gain` keeps its current value.
- **MEASURE:**
  - On each `sample_valid`: peak ← max(peak, mag) and count++.
  - On the WINDOW-th valid sample, that sample is included in the peak and the FSM goes to DECIDE.
- **DECIDE:** lasts one cycle. At its exit edge:
  - `peak_level` ← peak.
  - If peak > HIGH_THRESH and `gain` > GAIN_MIN: `gain`−1, `locked`←0, go to SETTLE.
  - Else if peak < LOW_THRESH and `gain` < GAIN_MAX: `gain`+1, `locked`←0, go to SETTLE.
  - Otherwise: `locked`←1, go to MEASURE.
  - Peak and count are cleared in every case.
  - A `sample_valid` arriving during DECIDE is dropped.
- **SETTLE:** counts SETTLE valid samples and discards them, then goes to MEASURE with count and peak at 0.
- **Disable:** `agc_enable` = 0 in any state forces MANUAL on the next edge and takes priority over every other transition. An in-progress window is abandoned.
- **Thresholds at the bound:** with `gain` already at a bound, a threshold violation produces no change. `locked` is then set to 1, which flags that the bound was hit but the signal is stable.
- **`gain_changed`:** asserts whenever the registered `gain` differs from its previous value, including manual-mode edits.

## Timing
- **Reset values:**
  - `gain` = GAIN_INIT.
  - `gain_changed` = 0, `peak_level` = 0, `locked` = 0.
  - State = MANUAL, counters = 0.
- **Registered outputs:** all outputs are registered. No combinational path from input to output.
- **Manual mode:** `gain` follows `manual_gain` with 1-cycle latency.
- **Automatic mode:**
  - DECIDE is entered the edge after the WINDOW-th valid sample.
  - `gain`, `peak_level` and `locked` update, and `gain_changed` pulses, at the edge ending DECIDE. That is 2 cycles after the final sample's strobe edge.
- **Settle time:** the first sample counted toward the next window is valid sample SETTLE+1 after the change.
- **Mid-operation reset:** `rst` asserted at any time returns immediately to the reset values, without waiting for a clock.

## Structure
- **Package `cic_agc_pkg`:**
  - State enum `agc_state_t`.
  - Function `sat_abs` (saturating magnitude).
  - Shared DATA_WIDTH/GAIN_WIDTH defaults used by the CIC and its top level.
- **Sub-module `cic_agc_peak_detector`:**
  - Contains the magnitude, running max and window counter.
  - Inputs: `clk`, `rst`, `clear`, `enable`, `sample_valid`, `sample`.
  - Outputs: `peak`, `window_done`.
- **FSM:** the FSM and gain register stay in the top module.

## Test plan
- **Manual mode:** `agc_enable`=0, `manual_gain`=60 → `gain`=52 one cycle later with a single `gain_changed` pulse. Then `manual_gain`=10 → `gain`=10.
- **Overload:** AGC on, `gain`=20, constant `sample`=2000 → after 256 valid samples, `peak_level`=2000 and `gain`=19. The next 8 samples are ignored, then a new window starts.
- **Weak signal and lock:** `sample` alternating ±300, `gain`=20 → one step to 21. Then ±700 samples (peak between thresholds) → `gain` held, `locked`=1.
- **Saturating magnitude and lower bound:** `sample`=−2048 at `gain`=0 → `peak_level`=2047, `gain` stays 0, `locked`=1, no `gain_changed`.
- **Disable mid-window:** drop `agc_enable` after 100 samples → MANUAL next edge, `gain`=`manual_gain`. Re-enable → the next decision occurs only after a full 256 fresh samples.
- **Async reset:** assert `rst` mid-SETTLE between clock edges → outputs reach reset values before the next edge. After release the FSM is in MANUAL.

Source files
------------

// File: rtl/cic_agc_pkg.sv
// Shared types and helpers for the CIC automatic gain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cic_agc_pkg;

   // Defaults shared with the CIC decimator and its top level.
   localparam int CIC_DATA_WIDTH = 12;
   localparam int CIC_GAIN_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_MANUAL  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DECIDE  = 2'd2,
      ST_SETTLE  = 2'd3
   } agc_state_t;

   // Magnitude of a w-bit signed value (sign-extended into s). The most
   // negative code has no positive twin, so it clamps to 2^(w-1)-1.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] s,
                                           input int unsigned w);
      logic signed [31:0] lim;
      lim = (32'sd1 <<< (w - 1)) - 32'sd1;
      if (s < -lim) begin
         return lim;
      end else if (s < 0) begin
         return -s;
      end else begin
         return s;
      end
   endfunction

endpackage

// File: rtl/cic_agc_peak_detector.sv
// Windowed peak-magnitude tracker: running max of |sample| over WINDOW valid samples.
// Latency: peak and window_done are registered, valid the cycle after the last strobe.
// Backpressure: none; once the window is full further strobes are ignored until clear.
module cic_agc_peak_detector
   import cic_agc_pkg::*;
#(
   parameter int DATA_WIDTH = CIC_DATA_WIDTH,
   parameter int WINDOW     = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         enable,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic        [DATA_WIDTH-2:0] peak,
   output logic                         window_done
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
   localparam logic [CW-1:0] WIN_FULL = CW'(WINDOW);

   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-2:0] peak_q, peak_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-2:0] mag;
   logic                  accept;

   assign mag    = (DATA_WIDTH-1)'(sat_abs(32'(sample), DATA_WIDTH));
   // Count saturates at WINDOW so the peak stays frozen while the FSM decides.
   assign accept = enable && sample_valid && (count_q != WIN_FULL);

   // Next-state for window count, running max and the done pulse.
   always_comb begin
      count_d = count_q;
      peak_d  = peak_q;
      done_d  = 1'b0;
      if (clear) begin
         count_d = '0;
         peak_d  = '0;
      end else if (accept) begin
         count_d = count_q + CW'(1);
         if (mag > peak_q) begin
            peak_d = mag;
         end
         done_d = (count_q == WIN_LAST);
      end
   end

   // Detector state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         peak_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         peak_q  <= peak_d;
         done_q  <= done_d;
      end
   end

   assign peak        = peak_q;
   assign window_done = done_q;

endmodule

// File: rtl/cic_agc.sv
// Automatic gain control for the CIC output shift, with manual fallback.
// Latency: gain moves 2 cycles after the last window strobe; manual gain follows in 1 cycle.
// Backpressure: none; strobes during DECIDE are dropped, strobes during SETTLE are discarded.
module cic_agc
   import cic_agc_pkg::*;
#(
   parameter int DATA_WIDTH  = CIC_DATA_WIDTH,
   parameter int GAIN_WIDTH  = CIC_GAIN_WIDTH,
   parameter int WINDOW      = 256,
   parameter int SETTLE      = 8,
   parameter int HIGH_THRESH = 1536,
   parameter int LOW_THRESH  = 640,
   parameter int GAIN_MIN    = 0,
   parameter int GAIN_MAX    = 52,
   parameter int GAIN_INIT   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic                         agc_enable,
   input  logic        [GAIN_WIDTH-1:0] manual_gain,
   output logic        [GAIN_WIDTH-1:0] gain,
   output logic                         gain_changed,
   output logic        [DATA_WIDTH-2:0] peak_level,
   output logic                         locked
);

   localparam int SCW = $clog2(SETTLE + 1);
   localparam logic [SCW-1:0]        SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [GAIN_WIDTH-1:0] G_MIN  = GAIN_WIDTH'(GAIN_MIN);
   localparam logic [GAIN_WIDTH-1:0] G_MAX  = GAIN_WIDTH'(GAIN_MAX);
   localparam logic [GAIN_WIDTH-1:0] G_INIT = GAIN_WIDTH'(GAIN_INIT);
   localparam logic [DATA_WIDTH-2:0] HI_TH  = (DATA_WIDTH-1)'(HIGH_THRESH);
   localparam logic [DATA_WIDTH-2:0] LO_TH  = (DATA_WIDTH-1)'(LOW_THRESH);

   agc_state_t            state_q, state_d;
   logic [GAIN_WIDTH-1:0] gain_q, gain_d;
   logic                  gain_changed_q, gain_changed_d;
   logic [DATA_WIDTH-2:0] peak_level_q, peak_level_d;
   logic                  locked_q, locked_d;
   logic [SCW-1:0]        settle_cnt_q, settle_cnt_d;

   logic                  det_clear;
   logic                  det_enable;
   logic [DATA_WIDTH-2:0] det_peak;
   logic                  det_done;
   logic [GAIN_WIDTH-1:0] manual_clamped;

   assign manual_clamped = (manual_gain > G_MAX) ? G_MAX : manual_gain;

   cic_agc_peak_detector #(
      .DATA_WIDTH (DATA_WIDTH),
      .WINDOW     (WINDOW)
   ) u_peak (
      .clk          (clk),
      .rst          (rst),
      .clear        (det_clear),
      .enable       (det_enable),
      .sample_valid (sample_valid),
      .sample       (sample),
      .peak         (det_peak),
      .window_done  (det_done)
   );

   // FSM next state, gain stepping and status; disable overrides everything.
   always_comb begin
      state_d      = state_q;
      gain_d       = gain_q;
      peak_level_d = peak_level_q;
      locked_d     = locked_q;
      settle_cnt_d = settle_cnt_q;
      det_clear    = 1'b1;
      det_enable   = 1'b0;

      if (!agc_enable) begin
         state_d      = ST_MANUAL;
         settle_cnt_d = '0;
         locked_d     = 1'b0;
         // Gain only tracks software once we are actually sitting in MANUAL.
         if (state_q == ST_MANUAL) begin
            gain_d = manual_clamped;
         end
      end else begin
         case (state_q)
            ST_MANUAL: begin
               state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               det_clear  = 1'b0;
               det_enable = 1'b1;
               if (det_done) begin
                  state_d = ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               peak_level_d = det_peak;
               settle_cnt_d = '0;
               if ((det_peak > HI_TH) && (gain_q > G_MIN)) begin
                  gain_d   = gain_q - GAIN_WIDTH'(1);
                  locked_d = 1'b0;
                  state_d  = ST_SETTLE;
               end else if ((det_peak < LO_TH) && (gain_q < G_MAX)) begin
                  gain_d   = gain_q + GAIN_WIDTH'(1);
                  locked_d = 1'b0;
                  state_d  = ST_SETTLE;
               end else begin
                  // Includes a violation at a bound: stable, nothing to move.
                  locked_d = 1'b1;
                  state_d  = ST_MEASURE;
               end
            end
            ST_SETTLE: begin
               if (sample_valid) begin
                  if (settle_cnt_q == SETTLE_LAST) begin
                     settle_cnt_d = '0;
                     state_d      = ST_MEASURE;
                  end else begin
                     settle_cnt_d = settle_cnt_q + SCW'(1);
                  end
               end
            end
            default: begin
               state_d = ST_MANUAL;
            end
         endcase
      end
   end

   // Change pulse covers both automatic steps and manual edits.
   always_comb begin
      gain_changed_d = (gain_d != gain_q);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_MANUAL;
         gain_q         <= G_INIT;
         gain_changed_q <= 1'b0;
         peak_level_q   <= '0;
         locked_q       <= 1'b0;
         settle_cnt_q   <= '0;
      end else begin
         state_q        <= state_d;
         gain_q         <= gain_d;
         gain_changed_q <= gain_changed_d;
         peak_level_q   <= peak_level_d;
         locked_q       <= locked_d;
         settle_cnt_q   <= settle_cnt_d;
      end
   end

   assign gain         = gain_q;
   assign gain_changed = gain_changed_q;
   assign peak_level   = peak_level_q;
   assign locked       = locked_q;

endmodule
